// File: rtl/dcache_wb.sv
// rtl/dcache_wb.sv - direct-mapped write-back write-allocate data cache with beat-serial memory port
module dcache_wb #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int SETS           = 64,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rd_en,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] WriteData,
    input  logic [2:0]            funct3,
    output logic [DATA_WIDTH-1:0] ReadData_c,
    output logic                  stall,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);
    localparam int OFF_W = $clog2(WORDS_PER_LINE);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = ADDR_WIDTH - IDX_W - OFF_W - 2;
    localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(WORDS_PER_LINE - 1);

    typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL, RESPOND} state_t;

    state_t            state_q, state_d;
    logic [OFF_W-1:0]  beat_q, beat_d;
    logic [SETS-1:0]   valid_q, valid_d, dirty_q, dirty_d;

    logic [TAG_W-1:0]      tag_ram  [SETS];
    logic [DATA_WIDTH-1:0] data_ram [SETS*WORDS_PER_LINE];

    logic [TAG_W-1:0]      req_tag;
    logic [IDX_W-1:0]      req_idx;
    logic [OFF_W-1:0]      req_off;
    logic                  req, hit;
    logic [DATA_WIDTH-1:0] cur_word, st_data, merged;
    logic [3:0]            be;

    logic                     data_we, tag_we;
    logic [IDX_W+OFF_W-1:0]   data_waddr;
    logic [DATA_WIDTH-1:0]    data_wdata;
    logic                     stall_c, req_c, we_c;
    logic [ADDR_WIDTH-1:0]    addr_c;
    logic [DATA_WIDTH-1:0]    wdata_c;

    assign req_tag  = addr[ADDR_WIDTH-1 -: TAG_W];
    assign req_idx  = addr[2+OFF_W +: IDX_W];
    assign req_off  = addr[2 +: OFF_W];
    assign req      = rd_en | wr_en;
    assign hit      = valid_q[req_idx] && (tag_ram[req_idx] == req_tag);
    assign cur_word = data_ram[{req_idx, req_off}];
    assign ReadData_c = cur_word;

    // Store lanes: unsupported sizes fall back to a full word, misaligned parts are aligned down.
    always_comb begin
        be      = 4'b1111;
        st_data = WriteData;
        case (funct3)
            3'b000: begin
                be      = 4'b0001 << addr[1:0];
                st_data = {4{WriteData[7:0]}};
            end
            3'b001: begin
                be      = addr[1] ? 4'b1100 : 4'b0011;
                st_data = {2{WriteData[15:0]}};
            end
            default: ;
        endcase
        for (int i = 0; i < 4; i++) begin
            merged[8*i +: 8] = be[i] ? st_data[8*i +: 8] : cur_word[8*i +: 8];
        end
    end

    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        valid_d    = valid_q;
        dirty_d    = dirty_q;
        stall_c    = 1'b0;
        req_c      = 1'b0;
        we_c       = 1'b0;
        addr_c     = '0;
        wdata_c    = '0;
        data_we    = 1'b0;
        data_waddr = {req_idx, req_off};
        data_wdata = merged;
        tag_we     = 1'b0;
        case (state_q)
            IDLE: begin
                if (req && hit && wr_en) begin
                    data_we          = 1'b1;
                    dirty_d[req_idx] = 1'b1;
                end
                if (req && !hit) begin
                    stall_c = 1'b1;
                    beat_d  = '0;
                    state_d = (valid_q[req_idx] && dirty_q[req_idx]) ? WRITEBACK : REFILL;
                end
            end
            WRITEBACK: begin
                stall_c = 1'b1;
                req_c   = 1'b1;
                we_c    = 1'b1;
                addr_c  = {tag_ram[req_idx], req_idx, beat_q, 2'b00};
                wdata_c = data_ram[{req_idx, beat_q}];
                if (mem_ack) begin
                    beat_d = beat_q + OFF_W'(1);
                    if (beat_q == LAST_BEAT) state_d = REFILL;
                end
            end
            REFILL: begin
                stall_c = 1'b1;
                req_c   = 1'b1;
                addr_c  = {req_tag, req_idx, beat_q, 2'b00};
                if (mem_ack) begin
                    data_we    = 1'b1;
                    data_waddr = {req_idx, beat_q};
                    data_wdata = mem_rdata;
                    beat_d     = beat_q + OFF_W'(1);
                    if (beat_q == LAST_BEAT) begin
                        valid_d[req_idx] = 1'b1;
                        dirty_d[req_idx] = 1'b0;
                        tag_we           = 1'b1;
                        state_d          = RESPOND;
                    end
                end
            end
            RESPOND: begin
                if (wr_en) begin
                    data_we          = 1'b1;
                    dirty_d[req_idx] = 1'b1;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are forced quiet while reset is asserted so an aborted beat drops at once.
    assign stall     = rst_n & stall_c;
    assign mem_req   = rst_n & req_c;
    assign mem_we    = rst_n & we_c;
    assign mem_addr  = rst_n ? addr_c  : '0;
    assign mem_wdata = rst_n ? wdata_c : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            beat_q  <= '0;
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            valid_q <= valid_d;
            dirty_q <= dirty_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && data_we) data_ram[data_waddr] <= data_wdata;
        if (rst_n && tag_we)  tag_ram[req_idx]     <= req_tag;
    end
endmodule

// File: tb/tb_dcache_wb.sv
// tb/tb_dcache_wb.sv - directed self-checking bench for dcache_wb with a behavioural memory
module tb_dcache_wb;
    logic        clk = 1'b0;
    logic        rst_n, rd_en, wr_en;
    logic [31:0] addr, WriteData;
    logic [2:0]  funct3;
    logic [31:0] ReadData_c;
    logic        stall, mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;

    dcache_wb dut (
        .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .wr_en(wr_en), .addr(addr),
        .WriteData(WriteData), .funct3(funct3), .ReadData_c(ReadData_c), .stall(stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } beat_t;

    logic [31:0] mem [1024];
    beat_t       log_q[$];
    int          ack_delay = 0;
    int          wait_cnt  = 0;
    int          unstable  = 0;
    logic        pend = 1'b0;
    beat_t       pb;
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Memory answers at the falling edge; the DUT sees mem_ack on the following rising edge.
    always @(negedge clk) begin
        if (mem_req) begin
            if (pend && (mem_addr != pb.addr || mem_we != pb.we || mem_wdata != pb.wdata))
                unstable++;
            pend     = 1'b1;
            pb.we    = mem_we;
            pb.addr  = mem_addr;
            pb.wdata = mem_wdata;
            if (wait_cnt == ack_delay) begin
                mem_ack   = 1'b1;
                mem_rdata = mem[mem_addr[11:2]];
                if (mem_we) mem[mem_addr[11:2]] = mem_wdata;
                log_q.push_back(pb);
                wait_cnt = 0;
                pend     = 1'b0;
            end else begin
                mem_ack = 1'b0;
                wait_cnt++;
            end
        end else begin
            mem_ack  = 1'b0;
            wait_cnt = 0;
            pend     = 1'b0;
        end
    end

    task automatic run_req(input string tag, input logic rd, input logic wr, input logic [31:0] a,
                           input logic [31:0] d, input logic [2:0] f3, output int sc);
        log_q.delete();
        rd_en = rd; wr_en = wr; addr = a; WriteData = d; funct3 = f3;
        sc = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!stall) break;
            sc++;
        end
        chk({tag, "_stall_end"}, {31'd0, stall}, 32'd0);
    endtask

    task automatic end_req();
        @(posedge clk); #1;
        rd_en = 1'b0; wr_en = 1'b0;
    endtask

    task automatic chk_beat(input string tag, input int i, input logic we, input logic [31:0] a,
                            input logic [31:0] d);
        if (i < log_q.size()) begin
            chk({tag, "_we"},   {31'd0, log_q[i].we}, {31'd0, we});
            chk({tag, "_addr"}, log_q[i].addr, a);
            if (we) chk({tag, "_wdata"}, log_q[i].wdata, d);
        end
    endtask

    int sc;

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = {16'hC0DE, 16'(i * 4)};
        rst_n = 1'b0; rd_en = 1'b1; wr_en = 1'b0; addr = 32'h100; WriteData = '0; funct3 = 3'b010;
        @(posedge clk); @(negedge clk);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        run_req("ld100", 1, 0, 32'h100, 0, 3'b010, sc);
        chk("ld100_stall", sc, 5);
        chk("ld100_data", ReadData_c, 32'hC0DE0100);
        chk("ld100_nbeats", log_q.size(), 4);
        for (int i = 0; i < 4; i++) chk_beat("ld100_beat", i, 1'b0, 32'h100 + 4 * i, 0);
        end_req();

        run_req("sw104", 0, 1, 32'h104, 32'hDEADBEEF, 3'b010, sc);
        chk("sw104_stall", sc, 0);
        chk("sw104_nbeats", log_q.size(), 0);
        end_req();
        run_req("lw104", 1, 0, 32'h104, 0, 3'b010, sc);
        chk("lw104_stall", sc, 0);
        chk("lw104_data", ReadData_c, 32'hDEADBEEF);
        end_req();

        run_req("sb105", 0, 1, 32'h105, 32'hFFFFFFAB, 3'b000, sc);
        end_req();
        run_req("lw104b", 1, 0, 32'h104, 0, 3'b010, sc);
        chk("sb105_data", ReadData_c, 32'hDEADABEF);
        end_req();

        run_req("sh10b", 0, 1, 32'h10B, 32'hFFFF1234, 3'b001, sc);
        end_req();
        run_req("sw10e", 0, 1, 32'h10E, 32'h55667788, 3'b011, sc);
        end_req();
        run_req("swboth", 1, 1, 32'h100, 32'h0BADF00D, 3'b010, sc);
        end_req();
        run_req("lw108", 1, 0, 32'h108, 0, 3'b010, sc);
        chk("sh10b_data", ReadData_c, 32'h12340108);
        end_req();
        run_req("lw10c", 1, 0, 32'h10C, 0, 3'b010, sc);
        chk("sw10e_data", ReadData_c, 32'h55667788);
        end_req();
        run_req("lw100", 1, 0, 32'h100, 0, 3'b010, sc);
        chk("swboth_data", ReadData_c, 32'h0BADF00D);
        end_req();

        run_req("ld500", 1, 0, 32'h500, 0, 3'b010, sc);
        chk("ld500_stall", sc, 9);
        chk("ld500_nbeats", log_q.size(), 8);
        chk_beat("ld500_wb0", 0, 1'b1, 32'h100, 32'h0BADF00D);
        chk_beat("ld500_wb1", 1, 1'b1, 32'h104, 32'hDEADABEF);
        chk_beat("ld500_wb2", 2, 1'b1, 32'h108, 32'h12340108);
        chk_beat("ld500_wb3", 3, 1'b1, 32'h10C, 32'h55667788);
        for (int i = 0; i < 4; i++) chk_beat("ld500_rf", 4 + i, 1'b0, 32'h500 + 4 * i, 0);
        chk("ld500_data", ReadData_c, 32'hC0DE0500);
        end_req();

        ack_delay = 3;
        run_req("dly100", 1, 0, 32'h100, 0, 3'b010, sc);
        chk("dly100_stall", sc, 17);
        chk("dly100_nbeats", log_q.size(), 4);
        for (int i = 0; i < 4; i++) chk_beat("dly100_beat", i, 1'b0, 32'h100 + 4 * i, 0);
        chk("dly100_data", ReadData_c, 32'h0BADF00D);
        end_req();
        run_req("sb100", 0, 1, 32'h100, 32'h00000077, 3'b000, sc);
        end_req();
        run_req("dly500", 1, 0, 32'h500, 0, 3'b010, sc);
        chk("dly500_stall", sc, 33);
        chk("dly500_nbeats", log_q.size(), 8);
        chk_beat("dly500_wb0", 0, 1'b1, 32'h100, 32'h0BADF077);
        chk_beat("dly500_rf3", 7, 1'b0, 32'h50C, 0);
        chk("dly_unstable", unstable, 0);
        end_req();
        ack_delay = 0;

        log_q.delete();
        rd_en = 1'b1; addr = 32'h200; funct3 = 3'b010;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b0; rd_en = 1'b0;
        @(negedge clk);
        chk("abort_mem_req", {31'd0, mem_req}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_stall", {31'd0, stall}, 32'd0);
        chk("post_rst_mem_req", {31'd0, mem_req}, 32'd0);
        @(posedge clk); #1;

        run_req("re200", 1, 0, 32'h200, 0, 3'b010, sc);
        chk("re200_stall", sc, 5);
        chk("re200_nbeats", log_q.size(), 4);
        for (int i = 0; i < 4; i++) chk_beat("re200_beat", i, 1'b0, 32'h200 + 4 * i, 0);
        chk("re200_data", ReadData_c, 32'hC0DE0200);
        end_req();
        run_req("re500", 1, 0, 32'h500, 0, 3'b010, sc);
        chk("re500_stall", sc, 5);
        chk("re500_data", ReadData_c, 32'hC0DE0500);
        end_req();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
